// File: rtl/id_stage_ctrl_if.sv
// Handshake and data bundle between fetch, the ID-stage controller and execute.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface id_stage_ctrl_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            flush;
  logic [24:0]     imm_instr;
  logic [2:0]      imm_sel;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_instr;
  logic [2:0]      ex_imm_sel;
  logic [4:0]      ex_rd;
  logic            ex_is_load;
  logic            ex_illegal;
  logic [15:0]     stall_count;

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, imm_instr, imm_sel, ex_valid, ex_pc, ex_instr,
           ex_imm_sel, ex_rd, ex_is_load, ex_illegal, stall_count
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, imm_instr, imm_sel, ex_valid, ex_pc, ex_instr,
           ex_imm_sel, ex_rd, ex_is_load, ex_illegal, stall_count
  );
endinterface

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: owns IF/ID and ID/EX registers, feeds the immediate
// generator, and inserts one bubble per load-use hazard.
module id_stage_ctrl #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  id_stage_ctrl_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] SEL_U     = 3'b000;
  localparam logic [2:0] SEL_J     = 3'b001;
  localparam logic [2:0] SEL_S     = 3'b010;
  localparam logic [2:0] SEL_B     = 3'b011;
  localparam logic [2:0] SEL_I     = 3'b100;
  localparam logic [2:0] SEL_ISH   = 3'b101;
  localparam logic [2:0] SEL_IU    = 3'b110;
  localparam logic [2:0] SEL_NONE  = 3'b111;

  // IF/ID register
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q,    id_pc_d;

  // ID/EX register
  logic            ex_valid_q,   ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
  logic [XLEN-1:0] ex_instr_q,   ex_instr_d;
  logic [2:0]      ex_imm_sel_q, ex_imm_sel_d;
  logic [4:0]      ex_rd_q,      ex_rd_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic            ex_illegal_q, ex_illegal_d;
  logic [15:0]     stall_count_q, stall_count_d;

  // Decode results
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [4:0] rs1_s, rs2_s, rd_s;
  logic [2:0] imm_sel_s;
  logic       illegal_s, is_load_s, uses_rs1_s, uses_rs2_s, writes_rd_s;

  // Handshake controls
  logic hazard_s, advance_s, bubble_s, if_ready_s, accept_s;

  assign opcode_s = id_instr_q[6:0];
  assign funct3_s = id_instr_q[14:12];
  assign rd_s     = id_instr_q[11:7];
  assign rs1_s    = id_instr_q[19:15];
  assign rs2_s    = id_instr_q[24:20];

  // Opcode decode into immediate format and register usage
  always_comb begin
    imm_sel_s   = SEL_NONE;
    illegal_s   = 1'b0;
    is_load_s   = 1'b0;
    uses_rs1_s  = 1'b1;
    uses_rs2_s  = 1'b0;
    writes_rd_s = 1'b1;
    case (opcode_s)
      OP_LUI, OP_AUIPC: begin
        imm_sel_s  = SEL_U;
        uses_rs1_s = 1'b0;
      end
      OP_JAL: begin
        imm_sel_s  = SEL_J;
        uses_rs1_s = 1'b0;
      end
      OP_STORE: begin
        imm_sel_s   = SEL_S;
        uses_rs2_s  = 1'b1;
        writes_rd_s = 1'b0;
      end
      OP_BRANCH: begin
        imm_sel_s   = SEL_B;
        uses_rs2_s  = 1'b1;
        writes_rd_s = 1'b0;
      end
      OP_OPIMM: begin
        if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
          imm_sel_s = SEL_ISH;
        end else begin
          imm_sel_s = SEL_I;
        end
      end
      OP_LOAD: begin
        imm_sel_s = SEL_I;
        is_load_s = 1'b1;
      end
      OP_JALR:   imm_sel_s = SEL_I;
      OP_SYSTEM: imm_sel_s = SEL_IU;
      OP_OP: begin
        imm_sel_s  = SEL_NONE;
        uses_rs2_s = 1'b1;
      end
      default: begin
        imm_sel_s = SEL_NONE;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Load-use detection and the advance/bubble/ready handshake
  always_comb begin
    hazard_s = id_valid_q & ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
               ((uses_rs1_s & (rs1_s == ex_rd_q)) | (uses_rs2_s & (rs2_s == ex_rd_q)));
    advance_s  = id_valid_q & ~hazard_s & (~ex_valid_q | bus.ex_ready);
    bubble_s   = hazard_s & bus.ex_ready;
    if_ready_s = ~bus.flush & (~id_valid_q | advance_s);
    accept_s   = bus.if_valid & if_ready_s;
  end

  // Next-state for IF/ID, ID/EX and the stall counter; flush overrides all
  always_comb begin
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_instr_d    = ex_instr_q;
    ex_imm_sel_d  = ex_imm_sel_q;
    ex_rd_d       = ex_rd_q;
    ex_is_load_d  = ex_is_load_q;
    ex_illegal_d  = ex_illegal_q;
    stall_count_d = stall_count_q;

    if (bus.flush) begin
      id_valid_d = 1'b0;
    end else if (accept_s) begin
      id_valid_d = 1'b1;
      id_instr_d = bus.if_instr;
      id_pc_d    = bus.if_pc;
    end else if (advance_s) begin
      id_valid_d = 1'b0;
    end else begin
      id_valid_d = id_valid_q;
    end

    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (advance_s) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = id_pc_q;
      ex_instr_d   = id_instr_q;
      ex_imm_sel_d = imm_sel_s;
      ex_rd_d      = writes_rd_s ? rd_s : 5'd0;
      ex_is_load_d = is_load_s;
      ex_illegal_d = illegal_s;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end

    if (!bus.flush && bubble_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_instr_q    <= '0;
      ex_imm_sel_q  <= 3'b000;
      ex_rd_q       <= 5'd0;
      ex_is_load_q  <= 1'b0;
      ex_illegal_q  <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_instr_q    <= ex_instr_d;
      ex_imm_sel_q  <= ex_imm_sel_d;
      ex_rd_q       <= ex_rd_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_illegal_q  <= ex_illegal_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.if_ready    = if_ready_s;
  assign bus.imm_instr   = id_instr_q[31:7];
  assign bus.imm_sel     = imm_sel_s;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_instr    = ex_instr_q;
  assign bus.ex_imm_sel  = ex_imm_sel_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_is_load  = ex_is_load_q;
  assign bus.ex_illegal  = ex_illegal_q;
  assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: decode, load-use bubble, backpressure,
// flush and mid-stream reset, with hand-computed expectations.
module tb_id_stage_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  id_stage_ctrl_if #(.XLEN(32)) bus ();

  id_stage_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [31:0] I_ADDI1 = 32'h00500093;
  localparam logic [31:0] I_ADDI2 = 32'h00A00113;
  localparam logic [31:0] I_ADDI3 = 32'h00F00193;
  localparam logic [31:0] I_SLLI  = 32'h00309093;
  localparam logic [31:0] I_CSRRS = 32'h300020F3;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_LW5   = 32'h00012283;
  localparam logic [31:0] I_ADD6  = 32'h00128333;
  localparam logic [31:0] I_LW0   = 32'h00012003;
  localparam logic [31:0] I_ADDX0 = 32'h00100333;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // reset state
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ex_pc", bus.ex_pc, 32'd0);
    chk("rst_ex_instr", bus.ex_instr, 32'd0);
    chk("rst_ex_imm_sel", {29'd0, bus.ex_imm_sel}, 32'd0);
    chk("rst_ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    chk("rst_ex_flags", {30'd0, bus.ex_is_load, bus.ex_illegal}, 32'd0);
    chk("rst_stall", {16'd0, bus.stall_count}, 32'd0);
    chk("rst_imm_instr", {7'd0, bus.imm_instr}, 32'd0);
    chk("rst_imm_sel", {29'd0, bus.imm_sel}, 32'd7);
    chk("rst_if_ready", {31'd0, bus.if_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // I-type decode
    offer(1'b1, I_ADDI1, 32'h100);
    tick();
    chk("addi_imm_sel", {29'd0, bus.imm_sel}, 32'd4);
    chk("addi_imm_instr", {7'd0, bus.imm_instr}, 32'h000A001);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("addi_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("addi_ex_rd", {27'd0, bus.ex_rd}, 32'd1);
    chk("addi_ex_illegal", {31'd0, bus.ex_illegal}, 32'd0);
    chk("addi_ex_pc", bus.ex_pc, 32'h100);
    tick();
    chk("addi_drain", {31'd0, bus.ex_valid}, 32'd0);

    // format sweep, back to back
    offer(1'b1, I_SLLI, 32'h110);
    tick();
    chk("slli_imm_sel", {29'd0, bus.imm_sel}, 32'd5);
    offer(1'b1, I_CSRRS, 32'h114);
    tick();
    chk("csr_imm_sel", {29'd0, bus.imm_sel}, 32'd6);
    chk("slli_ex_imm_sel", {29'd0, bus.ex_imm_sel}, 32'd5);
    offer(1'b1, I_BAD, 32'h118);
    tick();
    chk("bad_imm_sel", {29'd0, bus.imm_sel}, 32'd7);
    chk("csr_ex_imm_sel", {29'd0, bus.ex_imm_sel}, 32'd6);
    chk("csr_ex_rd", {27'd0, bus.ex_rd}, 32'd1);
    chk("csr_ex_illegal", {31'd0, bus.ex_illegal}, 32'd0);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("bad_ex_illegal", {31'd0, bus.ex_illegal}, 32'd1);
    chk("bad_ex_imm_sel", {29'd0, bus.ex_imm_sel}, 32'd7);
    chk("bad_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    tick();

    // load-use bubble
    offer(1'b1, I_LW5, 32'h200);
    tick();
    offer(1'b1, I_ADD6, 32'h204);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("lw_ex_is_load", {31'd0, bus.ex_is_load}, 32'd1);
    chk("lw_ex_rd", {27'd0, bus.ex_rd}, 32'd5);
    chk("hazard_if_ready", {31'd0, bus.if_ready}, 32'd0);
    tick();
    chk("bubble_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("bubble_stall", {16'd0, bus.stall_count}, 32'd1);
    chk("bubble_id_hold", {29'd0, bus.imm_sel}, 32'd7);
    tick();
    chk("add_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_ex_pc", bus.ex_pc, 32'h204);
    chk("add_ex_rd", {27'd0, bus.ex_rd}, 32'd6);
    chk("add_stall", {16'd0, bus.stall_count}, 32'd1);
    tick();

    // load to x0 never stalls
    offer(1'b1, I_LW0, 32'h220);
    tick();
    offer(1'b1, I_ADDX0, 32'h224);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    chk("x0_if_ready", {31'd0, bus.if_ready}, 32'd1);
    tick();
    chk("x0_ex_pc", bus.ex_pc, 32'h224);
    chk("x0_stall", {16'd0, bus.stall_count}, 32'd1);
    tick();

    // backpressure
    bus.ex_ready = 1'b0;
    offer(1'b1, I_ADDI1, 32'h300);
    tick();
    offer(1'b1, I_ADDI2, 32'h304);
    tick();
    offer(1'b1, I_ADDI3, 32'h308);
    chk("bp_if_ready0", {31'd0, bus.if_ready}, 32'd0);
    chk("bp_ex_pc0", bus.ex_pc, 32'h300);
    tick();
    chk("bp_ex_pc1", bus.ex_pc, 32'h300);
    chk("bp_ex_instr1", bus.ex_instr, I_ADDI1);
    chk("bp_id_hold1", {7'd0, bus.imm_instr}, I_ADDI2 >> 7);
    chk("bp_if_ready1", {31'd0, bus.if_ready}, 32'd0);
    tick();
    chk("bp_ex_pc2", bus.ex_pc, 32'h300);
    chk("bp_ex_rd2", {27'd0, bus.ex_rd}, 32'd1);
    bus.ex_ready = 1'b1;
    tick();
    chk("bp_rel_pc_b", bus.ex_pc, 32'h304);
    chk("bp_rel_rd_b", {27'd0, bus.ex_rd}, 32'd2);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_rel_pc_c", bus.ex_pc, 32'h308);
    chk("bp_rel_rd_c", {27'd0, bus.ex_rd}, 32'd3);
    tick();
    chk("bp_drain", {31'd0, bus.ex_valid}, 32'd0);

    // flush with both registers full and an offer pending
    bus.ex_ready = 1'b0;
    offer(1'b1, I_ADDI1, 32'h400);
    tick();
    offer(1'b1, I_ADDI2, 32'h404);
    tick();
    offer(1'b1, I_ADDI3, 32'h408);
    bus.flush = 1'b1;
    chk("flush_if_ready", {31'd0, bus.if_ready}, 32'd0);
    tick();
    bus.flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    bus.ex_ready = 1'b1;
    chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_stall", {16'd0, bus.stall_count}, 32'd1);
    tick();
    chk("flush_id_empty", {31'd0, bus.ex_valid}, 32'd0);

    // flush coinciding with a load-use hazard
    offer(1'b1, I_LW5, 32'h500);
    tick();
    offer(1'b1, I_ADD6, 32'h504);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flushhz_stall", {16'd0, bus.stall_count}, 32'd1);
    chk("flushhz_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    tick();
    chk("flushhz_id_empty", {31'd0, bus.ex_valid}, 32'd0);

    // mid-stream reset
    offer(1'b1, I_ADDI1, 32'h600);
    tick();
    offer(1'b1, I_ADDI2, 32'h604);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("mrst_ex_pc", bus.ex_pc, 32'd0);
    chk("mrst_ex_instr", bus.ex_instr, 32'd0);
    chk("mrst_ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    chk("mrst_stall", {16'd0, bus.stall_count}, 32'd0);
    chk("mrst_imm_instr", {7'd0, bus.imm_instr}, 32'd0);
    chk("mrst_imm_sel", {29'd0, bus.imm_sel}, 32'd7);
    chk("mrst_if_ready", {31'd0, bus.if_ready}, 32'd1);
    rst_n = 1'b1;
    offer(1'b1, I_ADDI3, 32'h700);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    tick();
    chk("mrst_resume_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("mrst_resume_pc", bus.ex_pc, 32'h700);
    chk("mrst_resume_rd", {27'd0, bus.ex_rd}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
